// File: rtl/cnt_seq_pkg.sv
// Shared types and default moduli for the alternating mod-5/mod-6 counter and its checker.
package cnt_seq_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } chk_state_t;

  localparam int CNT_SEQ_MOD_A = 5;
  localparam int CNT_SEQ_MOD_B = 6;

endpackage

// File: rtl/cnt_seq_sat_ctr.sv
// Saturating up-counter: increments on inc and sticks at all ones.
module cnt_seq_sat_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cnt_seq_checker.sv
// Lock-and-check monitor for the alternating mod-A/mod-B counter stream.
// Optional period counter built when CNT_SEQ_PERIOD_CNT_EN is defined.
//
// state  | meaning
// HUNT   | unlocked, looking for (MOD_A-1 or MOD_B-1) followed by 0
// LOCK_A | locked, expecting the phase A value in exp
// LOCK_B | locked, expecting the phase B value in exp
module cnt_seq_checker
  import cnt_seq_pkg::*;
#(
  parameter int CW    = 3,
  parameter int MOD_A = CNT_SEQ_MOD_A,
  parameter int MOD_B = CNT_SEQ_MOD_B,
  parameter int ERRW  = 8,
  parameter int PERW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CW-1:0]   cnt_in,
  output logic            locked,
  output logic            phase,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_cnt,
  output logic            period_done,
  output logic [PERW-1:0] period_cnt
);

  if (!(MOD_B > MOD_A && MOD_A >= 2 && MOD_B <= (2 ** CW))) begin : g_param_chk
    $fatal(1, "cnt_seq_checker: illegal MOD_A/MOD_B/CW combination");
  end

  localparam logic [CW-1:0] LAST_A = CW'(MOD_A - 1);
  localparam logic [CW-1:0] LAST_B = CW'(MOD_B - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  chk_state_t    state;
  logic [CW-1:0] prev;
  logic          prev_vld;
  logic [CW-1:0] exp;
  logic          hit;
  logic          miss;

  assign hit  = (cnt_in == exp);
  assign miss = in_valid && (state != HUNT) && !hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      prev      <= '0;
      prev_vld  <= 1'b0;
      exp       <= '0;
      locked    <= 1'b0;
      phase     <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        prev     <= cnt_in;
        prev_vld <= 1'b1;
        case (state)
          HUNT: begin
            if (prev_vld && (cnt_in == '0)) begin
              if (prev == LAST_A) begin
                state  <= LOCK_B;
                exp    <= ONE;
                locked <= 1'b1;
                phase  <= 1'b1;
              end else if (prev == LAST_B) begin
                state  <= LOCK_A;
                exp    <= ONE;
                locked <= 1'b1;
                phase  <= 1'b0;
              end
            end
          end
          LOCK_A: begin
            if (!hit) begin
              state     <= HUNT;
              exp       <= '0;
              locked    <= 1'b0;
              phase     <= 1'b0;
              err_pulse <= 1'b1;
            end else if (exp == LAST_A) begin
              state <= LOCK_B;
              exp   <= '0;
              phase <= 1'b1;
            end else begin
              exp <= exp + 1'b1;
            end
          end
          LOCK_B: begin
            if (!hit) begin
              state     <= HUNT;
              exp       <= '0;
              locked    <= 1'b0;
              phase     <= 1'b0;
              err_pulse <= 1'b1;
            end else if (exp == LAST_B) begin
              state <= LOCK_A;
              exp   <= '0;
              phase <= 1'b0;
            end else begin
              exp <= exp + 1'b1;
            end
          end
          default: begin
            state  <= HUNT;
            exp    <= '0;
            locked <= 1'b0;
            phase  <= 1'b0;
          end
        endcase
      end
    end
  end

  cnt_seq_sat_ctr #(.W(ERRW)) u_err_ctr (
    .clk (clk),
    .rst (rst),
    .inc (miss),
    .cnt (err_cnt)
  );

`ifdef CNT_SEQ_PERIOD_CNT_EN
  logic per_evt;

  // A mismatch on the final B slot fails hit, so it never counts as a period.
  assign per_evt = in_valid && (state == LOCK_B) && hit && (exp == LAST_B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_done <= 1'b0;
      period_cnt  <= '0;
    end else begin
      period_done <= per_evt;
      if (per_evt) begin
        period_cnt <= period_cnt + 1'b1;
      end
    end
  end
`else
  assign period_done = 1'b0;
  assign period_cnt  = '0;
`endif

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Directed self-checking bench for cnt_seq_checker with default parameters.
module tb_cnt_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  cnt_in;
  logic        locked;
  logic        phase;
  logic        err_pulse;
  logic [7:0]  err_cnt;
  logic        period_done;
  logic [15:0] period_cnt;

  int n_chk = 0;
  int n_err = 0;
  int e_err = 0;

  always #5 clk = ~clk;

  cnt_seq_checker dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .cnt_in      (cnt_in),
    .locked      (locked),
    .phase       (phase),
    .err_pulse   (err_pulse),
    .err_cnt     (err_cnt),
    .period_done (period_done),
    .period_cnt  (period_cnt)
  );

  // Period outputs only exist when the optional counter is built.
  function automatic int pexp(int v);
`ifdef CNT_SEQ_PERIOD_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string tag, int obs, int expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_all(string tag, int lk, int ph, int ep, int ec, int pd, int pc);
    chk({tag, ".locked"},      32'(locked),      lk);
    chk({tag, ".phase"},       32'(phase),       ph);
    chk({tag, ".err_pulse"},   32'(err_pulse),   ep);
    chk({tag, ".err_cnt"},     32'(err_cnt),     ec);
    chk({tag, ".period_done"}, 32'(period_done), pexp(pd));
    chk({tag, ".period_cnt"},  32'(period_cnt),  pexp(pc));
  endtask

  task automatic send(int v, bit vld);
    @(negedge clk);
    in_valid = vld;
    cnt_in   = 3'(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    cnt_in   = 3'd0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Hunt through 0..4, lock on the following 0 into phase B
    for (int i = 0; i < 5; i++) begin
      send(i, 1'b1);
      chk_all($sformatf("hunt%0d", i), 0, 0, 0, 0, 0, 0);
    end
    send(0, 1'b1); chk_all("lock_b", 1, 1, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) begin
      send(i, 1'b1);
      chk_all($sformatf("b%0d", i), 1, 1, 0, 0, 0, 0);
    end
    send(5, 1'b1); chk_all("b5_period", 1, 0, 0, 0, 1, 1);
    send(0, 1'b1); chk_all("a0", 1, 0, 0, 0, 0, 1);
    send(1, 1'b1); chk_all("a1", 1, 0, 0, 0, 0, 1);

    // Mismatch in phase A, then re-lock
    send(3, 1'b1); chk_all("a_miss", 0, 0, 1, 1, 0, 1);
    send(4, 1'b1); chk_all("relock4", 0, 0, 0, 1, 0, 1);
    send(0, 1'b1); chk_all("relock_b", 1, 1, 0, 1, 0, 1);
    send(5, 1'b1); chk_all("b_miss", 0, 0, 1, 2, 0, 1);
    send(0, 1'b1); chk_all("relock_a", 1, 0, 0, 2, 0, 1);

    // Valid gaps inside phase A
    send(1, 1'b1); chk_all("gap_a1", 1, 0, 0, 2, 0, 1);
    send(2, 1'b1); chk_all("gap_a2", 1, 0, 0, 2, 0, 1);
    for (int i = 0; i < 3; i++) begin
      send(7, 1'b0);
      chk_all($sformatf("idle%0d", i), 1, 0, 0, 2, 0, 1);
    end
    send(3, 1'b1); chk_all("gap_a3", 1, 0, 0, 2, 0, 1);
    send(4, 1'b1); chk_all("gap_a4", 1, 1, 0, 2, 0, 1);
    for (int i = 0; i < 5; i++) begin
      send(i, 1'b1);
      chk_all($sformatf("b2_%0d", i), 1, 1, 0, 2, 0, 1);
    end
    send(5, 1'b1); chk_all("period2", 1, 0, 0, 2, 1, 2);

    // Saturation: out-of-range value forces mismatch, then 5,0 re-locks
    e_err = 2;
    for (int i = 0; i < 300; i++) begin
      if (e_err < 255) e_err++;
      send(7, 1'b1);
      chk("sat.err_pulse", 32'(err_pulse), 1);
      chk("sat.err_cnt",   32'(err_cnt),   e_err);
      send(5, 1'b1);
      send(0, 1'b1);
      chk("sat.locked",    32'(locked),    1);
    end
    chk_all("sat_end", 1, 0, 0, 255, 0, 2);

    // Mismatch on the final B slot: error only, no period
    send(1, 1'b1); send(2, 1'b1); send(3, 1'b1); send(4, 1'b1);
    chk_all("to_b", 1, 1, 0, 255, 0, 2);
    for (int i = 0; i < 5; i++) send(i, 1'b1);
    send(3, 1'b1); chk_all("b_last_miss", 0, 0, 1, 255, 0, 2);

    // Async reset in the middle of LOCK_B
    send(4, 1'b1); send(0, 1'b1);
    send(1, 1'b1); send(2, 1'b1); send(3, 1'b1);
    chk_all("pre_rst", 1, 1, 0, 255, 0, 2);
    rst = 1'b1;
    #1;
    chk_all("mid_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    send(5, 1'b1); chk_all("post_rst5", 0, 0, 0, 0, 0, 0);
    send(0, 1'b1); chk_all("post_rst_lock", 1, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
